// File: rtl/fb_scanout_if.sv
// Framebuffer read port: word address out, data back a fixed number of cycles later.
interface fb_scanout_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, input mem_rdata);
  modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/fb_scanout.sv
// Framebuffer scanout: raster counters -> word address -> fixed-latency read ->
// pixel unpack/expand to RGB888, with sync/active delayed to stay aligned.
module fb_scanout #(
  parameter int          H_ACTIVE     = 1280,
  parameter int          V_ACTIVE     = 720,
  parameter int          SCALE_SHIFT  = 2,
  parameter logic [31:0] FB_BYTE_BASE = 32'hC00,
  parameter int          READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       h_count,
  input  logic [9:0]        v_count,
  input  logic              active_draw,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic              new_frame,
  input  logic [1:0]        fmt,
  fb_scanout_if.master      mem,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              h_sync_out,
  output logic              v_sync_out,
  output logic              active_out,
  output logic [1:0]        fmt_active
);

  localparam logic [10:0] H_END    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_END    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_MASK   = 10'((1 << SCALE_SHIFT) - 1);
  localparam logic [31:0] ROW_STEP = 32'(H_ACTIVE >> SCALE_SHIFT);

  // Per-pixel side info that travels alongside the memory read.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [1:0] fmt;
    logic [1:0] lane;
    logic       nib;
  } side_t;

  logic [31:0] row_base, pix_off, byte_off, byte_addr;
  logic        synced;
  logic        row_last;
  side_t [READ_LATENCY:0] side_pipe;
  side_t       s;
  logic [7:0]  px8;
  logic [15:0] px16;
  logic [3:0]  px4;
  logic [7:0]  r_n, g_n, b_n;

  // Raster position -> framebuffer byte offset for the active format.
  always_comb begin
    pix_off  = row_base + (32'(h_count) >> SCALE_SHIFT);
    row_last = (v_count & V_MASK) == V_MASK;
    case (fmt_active)
      2'b10:   byte_off = pix_off << 1;
      2'b11:   byte_off = pix_off >> 1;
      default: byte_off = pix_off;
    endcase
    byte_addr = FB_BYTE_BASE + byte_off;
  end

  // Row base tracking, format latch, address register and side-info pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_base     <= '0;
      synced       <= 1'b0;
      fmt_active   <= 2'b00;
      mem.mem_addr <= '0;
      side_pipe    <= '0;
    end else begin
      // Vertical blank resets row_base, which is what makes it trustworthy.
      if (v_count >= V_END) begin
        row_base <= '0;
        synced   <= 1'b1;
      end else if (h_count == H_END && row_last) begin
        row_base <= row_base + ROW_STEP;
      end
      if (new_frame) fmt_active <= fmt;
      mem.mem_addr <= byte_addr >> 2;
      side_pipe[0] <= '{hs: h_sync, vs: v_sync, act: active_draw, fmt: fmt_active,
                        lane: byte_off[1:0], nib: pix_off[0]};
      for (int i = 1; i <= READ_LATENCY; i++) side_pipe[i] <= side_pipe[i-1];
    end
  end

  // Lane select and bit-replication expansion once read data is valid.
  always_comb begin
    s    = side_pipe[READ_LATENCY];
    px8  = mem.mem_rdata[{s.lane, 3'b000} +: 8];
    px16 = s.lane[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    px4  = s.nib ? px8[7:4] : px8[3:0];
    case (s.fmt)
      2'b00: begin
        r_n = {px8[7:5], px8[7:5], px8[7:6]};
        g_n = {px8[4:2], px8[4:2], px8[4:3]};
        b_n = {4{px8[1:0]}};
      end
      2'b01: begin
        r_n = px8;
        g_n = px8;
        b_n = px8;
      end
      2'b10: begin
        r_n = {px16[15:11], px16[15:13]};
        g_n = {px16[10:5], px16[10:9]};
        b_n = {px16[4:0], px16[4:2]};
      end
      default: begin
        r_n = {px4, px4};
        g_n = {px4, px4};
        b_n = {px4, px4};
      end
    endcase
  end

  // Final output register; colour is blanked outside active or before first vblank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      active_out <= 1'b0;
    end else begin
      h_sync_out <= s.hs;
      v_sync_out <= s.vs;
      active_out <= s.act;
      if (s.act && synced) begin
        red   <= r_n;
        green <= g_n;
        blue  <= b_n;
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout with a 2-cycle read-latency memory model.
module tb_fb_scanout;
  logic        clk, rst;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        active_draw, h_sync, v_sync, new_frame;
  logic [1:0]  fmt, fmt_active;
  logic [7:0]  red, green, blue;
  logic        h_sync_out, v_sync_out, active_out;
  logic [23:0] rgb;
  int          checks = 0, failures = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] a1, a2;

  fb_scanout_if mem_if();

  fb_scanout dut (
    .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
    .active_draw(active_draw), .h_sync(h_sync), .v_sync(v_sync),
    .new_frame(new_frame), .fmt(fmt), .mem(mem_if),
    .red(red), .green(green), .blue(blue),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .active_out(active_out), .fmt_active(fmt_active)
  );

  always #5 clk = ~clk;
  assign rgb = {red, green, blue};

  // Two-stage read pipeline: data for mem_addr appears two edges later.
  always @(posedge clk) begin
    a1 <= mem_if.mem_addr;
    a2 <= a1;
  end
  assign mem_if.mem_rdata = mem[a2[9:0]];

  task automatic drive(input int h, input int v, input logic act);
    h_count = 11'(h);
    v_count = 10'(v);
    active_draw = act;
  endtask

  task automatic vblank(input logic [1:0] f);
    @(negedge clk); fmt = f; new_frame = 1; drive(0, 720, 0);
    @(negedge clk); new_frame = 0;
  endtask

  task automatic advance_rows(input int n);
    for (int v = 0; v < n; v++) begin
      @(negedge clk); drive(1280, v, 0);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      h_count = 11'($urandom); v_count = 10'($urandom);
      active_draw = 1'($urandom); h_sync = 1'($urandom); v_sync = 1'($urandom);
      new_frame = 1'($urandom); fmt = 2'($urandom);
    end
    @(negedge clk);
    checks++; if (mem_if.mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_if.mem_addr); end
    checks++; if (rgb !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=0", rgb); end
    checks++; if ({h_sync_out, v_sync_out, active_out} !== 3'b000) begin failures++; $display("FAIL reset_sync got=%b exp=000", {h_sync_out, v_sync_out, active_out}); end
    checks++; if (fmt_active !== 2'b00) begin failures++; $display("FAIL reset_fmt got=%b exp=00", fmt_active); end
    // Release and draw before any vblank: colour must stay dark.
    h_sync = 0; v_sync = 0; new_frame = 0; fmt = 0; rst = 1;
    mem[10'h300] = 32'h000000E0;
    drive(0, 0, 1);
    @(negedge clk); drive(1280, 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if ({active_out, rgb} !== {1'b1, 24'h0}) begin failures++; $display("FAIL unsynced_dark got=%b/%h exp=1/000000", active_out, rgb); end
  endtask

  task automatic test_rgb332;
    vblank(2'b00);
    mem[10'h300] = 32'h000049E0;
    mem[10'h350] = 32'h0000001C;
    @(negedge clk); drive(0, 0, 1);
    @(negedge clk);
    checks++; if (mem_if.mem_addr !== 32'h300) begin failures++; $display("FAIL rgb332_addr0 got=%h exp=300", mem_if.mem_addr); end
    drive(4, 0, 1);
    @(negedge clk);
    checks++; if (mem_if.mem_addr !== 32'h300) begin failures++; $display("FAIL rgb332_addr1 got=%h exp=300", mem_if.mem_addr); end
    drive(8, 0, 0);
    @(negedge clk); drive(1280, 0, 0);
    @(negedge clk);
    checks++; if ({active_out, rgb} !== {1'b1, 24'hFF0000}) begin failures++; $display("FAIL rgb332_px0 got=%b/%h exp=1/FF0000", active_out, rgb); end
    drive(1280, 1, 0);
    @(negedge clk);
    checks++; if (rgb !== 24'h494955) begin failures++; $display("FAIL rgb332_px1 got=%h exp=494955", rgb); end
    drive(1280, 2, 0);
    @(negedge clk);
    checks++; if ({active_out, rgb} !== {1'b0, 24'h0}) begin failures++; $display("FAIL rgb332_blank got=%b/%h exp=0/000000", active_out, rgb); end
    drive(1280, 3, 0);
    @(negedge clk); drive(0, 4, 1);
    @(negedge clk);
    checks++; if (mem_if.mem_addr !== 32'h350) begin failures++; $display("FAIL rgb332_row4_addr got=%h exp=350", mem_if.mem_addr); end
    drive(1280, 4, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (rgb !== 24'h00FF00) begin failures++; $display("FAIL rgb332_row4_px got=%h exp=00FF00", rgb); end
  endtask

  task automatic test_rgb565;
    vblank(2'b10);
    mem[10'h3A0] = 32'h07E0F800;
    @(negedge clk);
    checks++; if (fmt_active !== 2'b10) begin failures++; $display("FAIL rgb565_fmt got=%b exp=10", fmt_active); end
    advance_rows(4);
    @(negedge clk); drive(0, 4, 1);
    @(negedge clk);
    checks++; if (mem_if.mem_addr !== 32'h3A0) begin failures++; $display("FAIL rgb565_addr got=%h exp=3A0", mem_if.mem_addr); end
    drive(4, 4, 1);
    @(negedge clk); drive(1280, 4, 0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (rgb !== 24'hFF0000) begin failures++; $display("FAIL rgb565_red got=%h exp=FF0000", rgb); end
    @(negedge clk);
    checks++; if (rgb !== 24'h00FF00) begin failures++; $display("FAIL rgb565_green got=%h exp=00FF00", rgb); end
  endtask

  task automatic test_gray4;
    vblank(2'b11);
    mem[10'h300] = 32'h000000A3;
    @(negedge clk); drive(0, 0, 1);
    @(negedge clk);
    checks++; if (mem_if.mem_addr !== 32'h300) begin failures++; $display("FAIL gray4_addr got=%h exp=300", mem_if.mem_addr); end
    drive(4, 0, 1);
    @(negedge clk); drive(8, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (rgb !== 24'h333333) begin failures++; $display("FAIL gray4_lo got=%h exp=333333", rgb); end
    @(negedge clk);
    checks++; if (rgb !== 24'hAAAAAA) begin failures++; $display("FAIL gray4_hi got=%h exp=AAAAAA", rgb); end
  endtask

  task automatic test_fmt_hold;
    int vs [3];
    vs[0] = 0; vs[1] = 360; vs[2] = 719;
    fmt = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1280, vs[i], 0);
      @(negedge clk);
      checks++; if (fmt_active !== 2'b11) begin failures++; $display("FAIL fmt_hold_v%0d got=%b exp=11", vs[i], fmt_active); end
    end
    vblank(2'b00);
    checks++; if (fmt_active !== 2'b00) begin failures++; $display("FAIL fmt_update got=%b exp=00", fmt_active); end
  endtask

  task automatic test_sync_align;
    logic [15:0] pa, pb, pc;
    pa = 16'b1011_0100_1110_0001;
    pb = 16'b0110_1100_0011_1010;
    pc = 16'b1100_1010_0111_0110;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        checks++;
        if ({h_sync_out, v_sync_out, active_out} !== {pa[i-4], pb[i-4], pc[i-4]}) begin
          failures++;
          $display("FAIL sync_align_%0d got=%b exp=%b", i, {h_sync_out, v_sync_out, active_out}, {pa[i-4], pb[i-4], pc[i-4]});
        end
        if (!active_out) begin
          checks++;
          if (rgb !== 24'h0) begin failures++; $display("FAIL sync_blank_%0d got=%h exp=000000", i, rgb); end
        end
      end
      if (i < 16) begin
        h_sync = pa[i]; v_sync = pb[i]; drive(i, 720, pc[i]);
      end else begin
        h_sync = 0; v_sync = 0; drive(0, 720, 0);
      end
    end
  endtask

  task automatic test_midframe_reset;
    @(negedge clk); rst = 0; new_frame = 1; fmt = 2'b10; drive(0, 100, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1; new_frame = 0; fmt = 2'b00;
    checks++; if (fmt_active !== 2'b00) begin failures++; $display("FAIL reset_beats_newframe got=%b exp=00", fmt_active); end
    drive(0, 0, 1);
    @(negedge clk); drive(1280, 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if ({active_out, rgb} !== {1'b1, 24'h0}) begin failures++; $display("FAIL midreset_dark got=%b/%h exp=1/000000", active_out, rgb); end
    vblank(2'b00);
    @(negedge clk); drive(0, 0, 1);
    @(negedge clk); drive(1280, 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (rgb !== 24'hB600FF) begin failures++; $display("FAIL midreset_resume got=%h exp=B600FF", rgb); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    clk = 0; rst = 0;
    h_count = 0; v_count = 0; active_draw = 0; h_sync = 0; v_sync = 0;
    new_frame = 0; fmt = 0;
    test_reset;
    test_rgb332;
    test_rgb565;
    test_gray4;
    test_fmt_hold;
    test_sync_align;
    test_midframe_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
